// File: rtl/btn_pkg.sv
// Shared types and helpers for the button conditioner.
// Holds the per-channel FSM state encoding and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Width of a counter that must hold values 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Larger of two cycle counts; sizes the shared repeat counter.
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce FSM and pulse generation.
// Auto-repeat while held is built only when BTN_COND_REPEAT_EN is defined.
module btn_chan
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef BTN_COND_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync;

  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             rel_q;
  logic             rel_d;
  logic             rpt_fire;

  // Shift the raw level through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef BTN_COND_REPEAT_EN
  localparam int RPT_W = cnt_width(max_cycles(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;
  logic             rpt_phase_q;
  logic             rpt_phase_d;

  // Time the hold delay, then the repeat interval, while stably held.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    if (state_q == HELD && sync) begin
      if (!rpt_phase_q) begin
        if (rpt_cnt_q == HOLD_LAST) begin
          rpt_fire    = 1'b1;
          rpt_cnt_d   = '0;
          rpt_phase_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end else begin
        if (rpt_cnt_q == RPT_LAST) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
    end
  end

  // Repeat timer registers; cleared whenever the channel leaves HELD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Debounce FSM: accept a level change after enough stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          press_d = rpt_fire;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Channel state registers; reset clears everything mid-debounce too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: N_BTN independent debounced channels.
// Define BTN_COND_REPEAT_EN to add press auto-repeat while a button is held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse
);

  if (N_BTN < 1 || N_BTN > 32 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES > (1 << 24) ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_conditioner: parameter out of range");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_COND_REPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .raw           (btn_raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a run-length reference model.
// Honours BTN_COND_REPEAT_EN for the expected auto-repeat behaviour.
module tb_btn_conditioner;

  localparam int N  = 3;
  localparam int SY = 2;
  localparam int DB = 4;
  localparam int HO = 20;
  localparam int RP = 8;
`ifdef BTN_COND_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] l;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   sq[N][$];
  int   run[N];
  int   hcnt[N];
  bit   lvl[N];
  int   plog[N][$];
  int   rlog[N][$];
  int   mark;
  int   exp_q[$];

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN           (N),
    .SYNC_STAGES     (SY),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HO),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse)
  );

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      sq[c].delete();
      for (int k = 0; k < SY; k++) sq[c].push_back(1'b0);
      run[c]  = 0;
      hcnt[c] = 0;
      lvl[c]  = 1'b0;
    end
  endtask

  // Reference model: the input seen SY edges late; a level change is
  // accepted after DB consecutive differing samples.
  always @(posedge clk) begin
    exp_t e;
    bit   s;
    e = '0;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < N; c++) begin
        s = sq[c].pop_front();
        sq[c].push_back(btn_raw[c]);
        if (s != lvl[c]) begin
          run[c]++;
          hcnt[c] = 0;
          if (run[c] == DB) begin
            lvl[c] = s;
            run[c] = 0;
            if (s) e.p[c] = 1'b1;
            else   e.r[c] = 1'b1;
          end
        end else if (run[c] != 0) begin
          run[c] = 0;
        end else if (lvl[c] && RPT) begin
          hcnt[c]++;
          if (hcnt[c] == HO ||
              (hcnt[c] > HO && (hcnt[c] - HO) % RP == 0))
            e.p[c] = 1'b1;
        end
        e.l[c] = lvl[c];
      end
    end
    sb.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    a.l = level;
    a.p = press;
    a.r = release_pulse;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d", cyc);
    end else begin
      e = sb.pop_front();
      if (reset) e = '0;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d actual l=%b p=%b r=%b expected l=%b p=%b r=%b",
                 cyc, a.l, a.p, a.r, e.l, e.p, e.r);
      end
    end
    for (int c = 0; c < N; c++) begin
      if (press[c] === 1'b1) plog[c].push_back(cyc);
      if (release_pulse[c] === 1'b1) rlog[c].push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < N; c++) begin
      plog[c].delete();
      rlog[c].delete();
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic check_list(input string name, input int got[$],
                            input int base, input int expv[$]);
    check_int({name, "_count"}, got.size(), expv.size());
    for (int i = 0; i < got.size() && i < expv.size(); i++)
      check_int($sformatf("%s_%0d", name, i), got[i] - base, expv[i]);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    step(3);
    check_int("reset_level", int'(level), 0);
    check_int("reset_press", int'(press), 0);
    check_int("reset_release", int'(release_pulse), 0);
    reset = 1'b0;
    step(5);

    // Single press held 60 cycles, then released.
    clear_logs();
    btn_raw[0] = 1'b1;
    mark = cyc;
    if (RPT) exp_q = '{6, 26, 34, 42, 50, 58};
    else     exp_q = '{6};
    step(60);
    check_list("hold_press0", plog[0], mark, exp_q);
    btn_raw[0] = 1'b0;
    mark = cyc;
    step(10);
    exp_q = '{6};
    check_list("hold_release0", rlog[0], mark, exp_q);

    // Bouncing rise on channel 1.
    clear_logs();
    foreach (exp_q[i]) exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      btn_raw[1] = ((5'b01101 >> i) & 5'd1) != 0;
      step(1);
    end
    btn_raw[1] = 1'b1;
    mark = cyc;
    step(10);
    exp_q = '{6};
    check_list("bounce_press1", plog[1], mark, exp_q);

    // Simultaneous release of channels 0 and 2.
    btn_raw[0] = 1'b1;
    btn_raw[2] = 1'b1;
    step(10);
    clear_logs();
    btn_raw[0] = 1'b0;
    btn_raw[2] = 1'b0;
    mark = cyc;
    step(10);
    check_list("sim_release0", rlog[0], mark, exp_q);
    check_list("sim_release2", rlog[2], mark, exp_q);
    check_int("sim_release1_count", rlog[1].size(), 0);
    if (rlog[0].size() > 0 && rlog[2].size() > 0)
      check_int("sim_release_same", rlog[0][0], rlog[2][0]);

    // Reset mid-debounce on channel 0 while channel 1 is held.
    btn_raw[0] = 1'b1;
    step(5);
    reset = 1'b1;
    #1;
    check_int("midrst_level", int'(level), 0);
    check_int("midrst_press", int'(press), 0);
    check_int("midrst_release", int'(release_pulse), 0);
    step(2);
    clear_logs();
    reset = 1'b0;
    mark = cyc;
    step(10);
    check_list("postrst_press0", plog[0], mark, exp_q);
    check_list("postrst_press1", plog[1], mark, exp_q);

    // Randomised traffic with occasional resets.
    btn_raw = '0;
    step(10);
    for (int n = 0; n < 3000; n++) begin
      int k;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, N - 1);
        btn_raw[k] = ~btn_raw[k];
      end
      if ($urandom_range(0, 3) == 0) btn_raw[0] = btn_raw[1];
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      step(1);
    end
    reset = 1'b0;
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
